// File: rtl/fifosync_flex_pkg.sv
// fifosync_flex_pkg
//   Shared elaboration helpers for the fifosync_flex FIFO family:
//   depth derivation from the address width, occupancy-counter width,
//   and range checking of the almost-full / almost-empty thresholds.
//   No ports; imported by fifosync_flex and fifosync_flex_ram.
package fifosync_flex_pkg;

    // Number of storage entries for a given address width.
    function automatic int depth_of(input int aw);
        return 1 << aw;
    endfunction

    // The counter must represent 0..DEPTH inclusive, hence one extra bit.
    function automatic int cnt_w(input int aw);
        return aw + 1;
    endfunction

    // Threshold levels are meaningful only in the range 0..DEPTH.
    function automatic bit lvl_ok(input int lvl, input int aw);
        return (lvl >= 0) && (lvl <= depth_of(aw));
    endfunction

endpackage

// File: rtl/fifosync_flex_ram.sv
// fifosync_flex_ram
//   Simple dual-port DW x DEPTH storage array for fifosync_flex.
//   Synchronous write. Read port is registered in standard mode and
//   asynchronous when FIFOSYNC_FWFT_EN is defined. The array itself is
//   never reset; only the standard-mode output register is.
// Ports
//   clk    in  1   clock
//   rst    in  1   async active-high reset (output register only)
//   we     in  1   write enable
//   waddr  in  AW  write address
//   wdata  in  DW  write data
//   re     in  1   read enable (loads output register, standard mode)
//   raddr  in  AW  read address
//   rdata  out DW  read data
// Configuration macro: FIFOSYNC_FWFT_EN
module fifosync_flex_ram
    import fifosync_flex_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    localparam int DEPTH = depth_of(AW);

    logic [DW-1:0] mem_r [0:DEPTH-1];

    // Storage write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

`ifdef FIFOSYNC_FWFT_EN
    // Reset and read enable play no role when the head word is shown combinationally.
    logic unused_s;
    assign unused_s = rst ^ re;
    assign rdata    = mem_r[raddr];
`else
    logic [DW-1:0] rdata_r;

    // Registered read port: holds its value except on an accepted pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_r <= {DW{1'b0}};
        end else if (re) begin
            rdata_r <= mem_r[raddr];
        end
    end

    assign rdata = rdata_r;
`endif

endmodule

// File: rtl/fifosync_flex.sv
// fifosync_flex
//   Parametrised single-clock FIFO with occupancy count, programmable
//   almost-full / almost-empty levels, sticky overflow / underflow flags,
//   synchronous flush (clr) and a read-valid strobe.
// Ports
//   clk          in  1     clock (rising edge)
//   rst          in  1     async active-high reset
//   clr          in  1     synchronous flush, overrides wr_en/rd_en
//   wr_en        in  1     push request
//   wr_data      in  DW    push data
//   rd_en        in  1     pop request
//   rd_data      out DW    popped word (std) / head word (FWFT)
//   rd_valid     out 1     rd_data freshly popped (std) / FIFO non-empty (FWFT)
//   full         out 1     count == DEPTH
//   empty        out 1     count == 0
//   almost_full  out 1     free slots <= AF_LVL
//   almost_empty out 1     count <= AE_LVL
//   count        out AW+1  occupancy
//   overflow     out 1     sticky: push attempted while full
//   underflow    out 1     sticky: pop attempted while empty
// Configuration macro: FIFOSYNC_FWFT_EN selects first-word-fall-through reads.
module fifosync_flex
    import fifosync_flex_pkg::*;
#(
    parameter int DW     = 32,
    parameter int AW     = 6,
    parameter int AF_LVL = 4,
    parameter int AE_LVL = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic          almost_empty,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic          underflow
);

    localparam int DEPTH = depth_of(AW);
    localparam int CW    = cnt_w(AW);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LVL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LVL);

    if (!lvl_ok(AF_LVL, AW)) begin : g_af_bad
        $error("fifosync_flex: AF_LVL must lie within 0..DEPTH");
    end
    if (!lvl_ok(AE_LVL, AW)) begin : g_ae_bad
        $error("fifosync_flex: AE_LVL must lie within 0..DEPTH");
    end

    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] cnt_r;
    logic          ovf_r;
    logic          udf_r;
    logic          wr_acc_s;
    logic          rd_acc_s;

    // Status flags derive only from the registered count.
    assign full         = (cnt_r == DEPTH_C);
    assign empty        = (cnt_r == {CW{1'b0}});
    assign almost_full  = ((DEPTH_C - cnt_r) <= AF_C);
    assign almost_empty = (cnt_r <= AE_C);
    assign count        = cnt_r;
    assign overflow     = ovf_r;
    assign underflow    = udf_r;

    // A flush suppresses both ports so nothing moves in the flush cycle.
    assign wr_acc_s = wr_en && !full  && !clr;
    assign rd_acc_s = rd_en && !empty && !clr;

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            cnt_r    <= {CW{1'b0}};
        end else if (clr) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            cnt_r    <= {CW{1'b0}};
        end else begin
            if (wr_acc_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (rd_acc_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            if (wr_acc_s && !rd_acc_s) begin
                cnt_r <= cnt_r + CW'(1);
            end else if (rd_acc_s && !wr_acc_s) begin
                cnt_r <= cnt_r - CW'(1);
            end
        end
    end

    // Sticky error flags; only reset or flush clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_r <= 1'b0;
            udf_r <= 1'b0;
        end else if (clr) begin
            ovf_r <= 1'b0;
            udf_r <= 1'b0;
        end else begin
            if (wr_en && full) begin
                ovf_r <= 1'b1;
            end
            if (rd_en && empty) begin
                udf_r <= 1'b1;
            end
        end
    end

`ifdef FIFOSYNC_FWFT_EN
    // Head word is always presented while anything is stored.
    assign rd_valid = !empty;
`else
    logic rd_valid_r;

    // One-cycle strobe following each accepted pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid_r <= 1'b0;
        end else if (clr) begin
            rd_valid_r <= 1'b0;
        end else begin
            rd_valid_r <= rd_acc_s;
        end
    end

    assign rd_valid = rd_valid_r;
`endif

    fifosync_flex_ram #(
        .DW (DW),
        .AW (AW)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_acc_s),
        .waddr (wr_ptr_r),
        .wdata (wr_data),
        .re    (rd_acc_s),
        .raddr (rd_ptr_r),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_fifosync_flex.sv
// tb_fifosync_flex
//   Self-checking bench for fifosync_flex (DW=8, AW=2, AF_LVL=1, AE_LVL=1).
//   A queue-based reference model tracks expected contents and flags.
module tb_fifosync_flex;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [2:0] count;
    logic       overflow;
    logic       underflow;

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [7:0] mq[$];
    logic       m_ovf;
    logic       m_udf;
    logic       m_rv;
    logic [7:0] m_rdata;

`ifdef FIFOSYNC_FWFT_EN
    localparam bit FWFT = 1'b1;
`else
    localparam bit FWFT = 1'b0;
`endif

    fifosync_flex #(
        .DW     (8),
        .AW     (2),
        .AF_LVL (1),
        .AE_LVL (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .clr          (clr),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        mq.delete();
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
        m_rv    = 1'b0;
        m_rdata = 8'h00;
    endtask

    // One clock edge of FIFO behaviour, using pre-edge occupancy for acceptance.
    task automatic model_step(input bit w, input logic [7:0] d, input bit r, input bit c);
        bit was_full;
        bit was_empty;
        was_full  = (mq.size() == 4);
        was_empty = (mq.size() == 0);
        m_rv = 1'b0;
        if (c) begin
            mq.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            if (r && !was_empty) begin
                m_rdata = mq.pop_front();
                m_rv    = 1'b1;
            end else if (r) begin
                m_udf = 1'b1;
            end
            if (w && !was_full) begin
                mq.push_back(d);
            end else if (w) begin
                m_ovf = 1'b1;
            end
        end
        if (FWFT) begin
            m_rv = (mq.size() != 0);
            if (m_rv) m_rdata = mq[0];
        end
    endtask

    // Drive one cycle of inputs, advance the model, and settle 1ns after the edge.
    task automatic tick(input bit w, input logic [7:0] d, input bit r, input bit c);
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        clr     = c;
        @(posedge clk);
        model_step(w, d, r, c);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        clr   = 1'b0;
    endtask

    task automatic test_reset();
        tests++; if (count !== 3'd0)      begin fails++; $display("FAIL rst_count got %0d exp 0", count); end
        tests++; if (empty !== 1'b1)      begin fails++; $display("FAIL rst_empty got %b exp 1", empty); end
        tests++; if (almost_empty !== 1'b1) begin fails++; $display("FAIL rst_aempty got %b exp 1", almost_empty); end
        tests++; if (full !== 1'b0)       begin fails++; $display("FAIL rst_full got %b exp 0", full); end
        tests++; if (almost_full !== 1'b0) begin fails++; $display("FAIL rst_afull got %b exp 0", almost_full); end
        tests++; if (rd_valid !== 1'b0)   begin fails++; $display("FAIL rst_rvalid got %b exp 0", rd_valid); end
        tests++; if ({overflow, underflow} !== 2'b00) begin fails++; $display("FAIL rst_flags got %b exp 00", {overflow, underflow}); end
`ifndef FIFOSYNC_FWFT_EN
        tests++; if (rd_data !== 8'h00)   begin fails++; $display("FAIL rst_rdata got %h exp 00", rd_data); end
`endif
    endtask

    task automatic test_reset_midstream();
        for (int i = 0; i < 3; i++) tick(1'b1, 8'(8'h61 + i), 1'b0, 1'b0);
        tests++; if (count !== 3'd3) begin fails++; $display("FAIL mid_pre_count got %0d exp 3", count); end
        #2 rst = 1'b1;
        #1;
        tests++; if (count !== 3'd0) begin fails++; $display("FAIL mid_count got %0d exp 0", count); end
        tests++; if (empty !== 1'b1) begin fails++; $display("FAIL mid_empty got %b exp 1", empty); end
        tests++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL mid_rvalid got %b exp 0", rd_valid); end
        model_reset();
        #2 rst = 1'b0;
    endtask

    task automatic test_fill();
        logic [7:0] v;
        for (int i = 0; i < 4; i++) begin
            v = 8'(8'h11 * (i + 1));
            tick(1'b1, v, 1'b0, 1'b0);
            tests++; if (count !== 3'(i + 1)) begin fails++; $display("FAIL fill_count i=%0d got %0d exp %0d", i, count, i + 1); end
            tests++; if (almost_full !== (i >= 2)) begin fails++; $display("FAIL fill_afull i=%0d got %b exp %b", i, almost_full, (i >= 2)); end
            tests++; if (full !== (i == 3)) begin fails++; $display("FAIL fill_full i=%0d got %b exp %b", i, full, (i == 3)); end
        end
        tick(1'b1, 8'h55, 1'b0, 1'b0);
        tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL fill_ovf got %b exp 1", overflow); end
        tests++; if (count !== 3'd4) begin fails++; $display("FAIL fill_ovf_count got %0d exp 4", count); end
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 8'h00, 1'b1, 1'b0);
            tests++; if (count !== 3'(3 - i)) begin fails++; $display("FAIL drain_count i=%0d got %0d exp %0d", i, count, 3 - i); end
`ifndef FIFOSYNC_FWFT_EN
            v = 8'(8'h11 * (i + 1));
            tests++; if (rd_data !== v) begin fails++; $display("FAIL drain_data i=%0d got %h exp %h", i, rd_data, v); end
            tests++; if (rd_valid !== 1'b1) begin fails++; $display("FAIL drain_rvalid i=%0d got %b exp 1", i, rd_valid); end
`endif
        end
        tick(1'b0, 8'h00, 1'b0, 1'b0);
        tests++; if (rd_valid !== m_rv) begin fails++; $display("FAIL idle_rvalid got %b exp %b", rd_valid, m_rv); end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 6; i++) begin
            tick(1'b1, 8'(8'hA0 + i), (i > 0), 1'b0);
            tests++; if (count > 3'd1) begin fails++; $display("FAIL wrap_count i=%0d got %0d exp <=1", i, count); end
`ifndef FIFOSYNC_FWFT_EN
            if (i > 0) begin
                tests++; if (rd_data !== 8'(8'hA0 + i - 1)) begin fails++; $display("FAIL wrap_data i=%0d got %h exp %h", i, rd_data, 8'(8'hA0 + i - 1)); end
            end
`endif
        end
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        tests++; if (count !== 3'd0) begin fails++; $display("FAIL wrap_end_count got %0d exp 0", count); end
        tests++; if (rd_data !== m_rdata && !(FWFT && mq.size() == 0)) begin fails++; $display("FAIL wrap_end_data got %h exp %h", rd_data, m_rdata); end
    endtask

    task automatic test_simultaneous();
        tick(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) tick(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        tick(1'b1, 8'h99, 1'b1, 1'b0);
        tests++; if (count !== 3'd3) begin fails++; $display("FAIL simfull_count got %0d exp 3", count); end
        tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL simfull_ovf got %b exp 1", overflow); end
`ifndef FIFOSYNC_FWFT_EN
        tests++; if (rd_data !== 8'hC0) begin fails++; $display("FAIL simfull_data got %h exp c0", rd_data); end
`endif
        tick(1'b0, 8'h00, 1'b0, 1'b1);
        tick(1'b1, 8'h7E, 1'b1, 1'b0);
        tests++; if (count !== 3'd1) begin fails++; $display("FAIL simempty_count got %0d exp 1", count); end
        tests++; if (underflow !== 1'b1) begin fails++; $display("FAIL simempty_udf got %b exp 1", underflow); end
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL simempty_ovf got %b exp 0", overflow); end
        tick(1'b0, 8'h00, 1'b1, 1'b0);
`ifndef FIFOSYNC_FWFT_EN
        tests++; if (rd_data !== 8'h7E) begin fails++; $display("FAIL simempty_data got %h exp 7e", rd_data); end
`endif
        tests++; if (empty !== 1'b1) begin fails++; $display("FAIL simempty_empty got %b exp 1", empty); end
    endtask

    task automatic test_clr();
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b1, 8'(8'h31 + i), 1'b0, 1'b0);
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        tick(1'b1, 8'hEE, 1'b1, 1'b1);
        tests++; if (count !== 3'd0) begin fails++; $display("FAIL clr_count got %0d exp 0", count); end
        tests++; if (empty !== 1'b1) begin fails++; $display("FAIL clr_empty got %b exp 1", empty); end
        tests++; if ({overflow, underflow} !== 2'b00) begin fails++; $display("FAIL clr_flags got %b exp 00", {overflow, underflow}); end
        tests++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL clr_rvalid got %b exp 0", rd_valid); end
`ifndef FIFOSYNC_FWFT_EN
        tests++; if (rd_data !== 8'h31) begin fails++; $display("FAIL clr_data got %h exp 31", rd_data); end
`endif
    endtask

`ifdef FIFOSYNC_FWFT_EN
    task automatic test_fwft();
        tick(1'b0, 8'h00, 1'b0, 1'b1);
        tick(1'b1, 8'h5A, 1'b0, 1'b0);
        tests++; if (rd_valid !== 1'b1) begin fails++; $display("FAIL fwft_rvalid got %b exp 1", rd_valid); end
        tests++; if (rd_data !== 8'h5A) begin fails++; $display("FAIL fwft_data got %h exp 5a", rd_data); end
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        tests++; if (empty !== 1'b1) begin fails++; $display("FAIL fwft_empty got %b exp 1", empty); end
    endtask
`endif

    task automatic test_random();
        bit w;
        bit r;
        bit c;
        int sz;
        for (int n = 0; n < 400; n++) begin
            w = ($urandom_range(0, 99) < ((n % 100) < 50 ? 75 : 25));
            r = ($urandom_range(0, 99) < ((n % 100) < 50 ? 35 : 70));
            c = ($urandom_range(0, 39) == 0);
            tick(w, 8'($urandom), r, c);
            sz = mq.size();
            tests++; if (count !== 3'(sz)) begin fails++; $display("FAIL rnd_count n=%0d got %0d exp %0d", n, count, sz); end
            tests++; if (full !== (sz == 4)) begin fails++; $display("FAIL rnd_full n=%0d got %b exp %b", n, full, (sz == 4)); end
            tests++; if (empty !== (sz == 0)) begin fails++; $display("FAIL rnd_empty n=%0d got %b exp %b", n, empty, (sz == 0)); end
            tests++; if (almost_full !== ((4 - sz) <= 1)) begin fails++; $display("FAIL rnd_afull n=%0d got %b exp %b", n, almost_full, ((4 - sz) <= 1)); end
            tests++; if (almost_empty !== (sz <= 1)) begin fails++; $display("FAIL rnd_aempty n=%0d got %b exp %b", n, almost_empty, (sz <= 1)); end
            tests++; if (overflow !== m_ovf) begin fails++; $display("FAIL rnd_ovf n=%0d got %b exp %b", n, overflow, m_ovf); end
            tests++; if (underflow !== m_udf) begin fails++; $display("FAIL rnd_udf n=%0d got %b exp %b", n, underflow, m_udf); end
            tests++; if (rd_valid !== m_rv) begin fails++; $display("FAIL rnd_rvalid n=%0d got %b exp %b", n, rd_valid, m_rv); end
            if (!(FWFT && sz == 0)) begin
                tests++; if (rd_data !== m_rdata) begin fails++; $display("FAIL rnd_data n=%0d got %h exp %h", n, rd_data, m_rdata); end
            end
        end
    endtask

    initial begin
        rst     = 1'b1;
        clr     = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wr_data = 8'h00;
        model_reset();
        #2;
        test_reset();
        #10 rst = 1'b0;
        test_reset_midstream();
        test_fill();
        test_wrap();
        test_simultaneous();
        test_clr();
`ifdef FIFOSYNC_FWFT_EN
        test_fwft();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
